// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch stage and its IF/ID register.
package cpu_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a bubble enters.
import cpu_pkg::*;

module ifid_reg #(
  parameter int PC_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   hold_i,
  input  logic                   load_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [PC_WIDTH-1:0]    pcPlus4_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]    pcPlus4_o,
  output logic                   valid_o
);

  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pcPlus4_q, pcPlus4_d;
  logic                   valid_q, valid_d;

  // A bubble keeps the last pc_plus4 so decode never sees a spurious PC change.
  always_comb begin
    instr_d   = instr_q;
    pcPlus4_d = pcPlus4_q;
    valid_d   = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (hold_i) begin
      instr_d   = instr_q;
      pcPlus4_d = pcPlus4_q;
      valid_d   = valid_q;
    end else if (load_i) begin
      instr_d   = instr_i;
      pcPlus4_d = pcPlus4_i;
      valid_d   = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pcPlus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcPlus4_q <= pcPlus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pcPlus4_o = pcPlus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with one outstanding imem request, stall buffer and branch redirect.
// Define FETCH_PERF_EN to add the perf_fetched/perf_stall/perf_flush counter outputs.
import cpu_pkg::*;

module fetch_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall_d,
  input  logic                   redirect_d,
  input  logic [PC_WIDTH-1:0]    redirect_pc_d,
  output logic [INSTR_WIDTH-1:0] instr_d,
  output logic [PC_WIDTH-1:0]    pc_plus4_d,
  output logic                   valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stall,
  output logic [31:0]            perf_flush
`endif
);

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    fetchPc_q, fetchPc_d;
  logic                   kill_q, kill_d;
  logic [INSTR_WIDTH-1:0] buf_q, buf_d;

  logic                   deliver;
  logic [INSTR_WIDTH-1:0] deliverInstr;
  logic [PC_WIDTH-1:0]    deliverPc4;
  logic [PC_WIDTH-1:0]    fetchPcPlus4;

  assign fetchPcPlus4 = fetchPc_q + PC_STEP;
  assign imem_addr    = pc_q;

  // While in HOLD, pc_q already equals the buffered word's fetch PC + 4.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetchPc_d    = fetchPc_q;
    kill_d       = kill_q;
    buf_d        = buf_q;
    deliver      = 1'b0;
    deliverInstr = imem_rdata;
    deliverPc4   = fetchPcPlus4;
    imem_req     = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          fetchPc_d = pc_q;
          state_d   = WAIT;
          if (redirect_d) kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
          kill_d  = 1'b0;
          if (!kill_q && !redirect_d) begin
            pc_d = fetchPcPlus4;
            if (stall_d) begin
              buf_d   = imem_rdata;
              state_d = HOLD;
            end else begin
              deliver = 1'b1;
            end
          end
        end else if (redirect_d) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_d) begin
          state_d = REQ;
        end else if (!stall_d) begin
          deliver      = 1'b1;
          deliverInstr = buf_q;
          deliverPc4   = pc_q;
          state_d      = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_d) pc_d = {redirect_pc_d[PC_WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      fetchPc_q <= RESET_PC;
      kill_q    <= 1'b0;
      buf_q     <= NOP_INSTR;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fetchPc_q <= fetchPc_d;
      kill_q    <= kill_d;
      buf_q     <= buf_d;
    end
  end

  ifid_reg #(
    .PC_WIDTH(PC_WIDTH)
  ) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (redirect_d),
    .hold_i   (stall_d),
    .load_i   (deliver),
    .instr_i  (deliverInstr),
    .pcPlus4_i(deliverPc4),
    .instr_o  (instr_d),
    .pcPlus4_o(pc_plus4_d),
    .valid_o  (valid_d)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perfFetched_q, perfStall_q, perfFlush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfFetched_q <= '0;
      perfStall_q   <= '0;
      perfFlush_q   <= '0;
    end else begin
      perfFetched_q <= perfFetched_q + {31'b0, deliver};
      perfStall_q   <= perfStall_q + {31'b0, stall_d};
      perfFlush_q   <= perfFlush_q + {31'b0, redirect_d};
    end
  end

  assign perf_fetched = perfFetched_q;
  assign perf_stall   = perfStall_q;
  assign perf_flush   = perfFlush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table plus an imem-response scoreboard.
// Build with FETCH_PERF_EN defined to also check the performance counters.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        redirect_d;
  logic [31:0] redirect_pc_d;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

  always #5 clk = ~clk;

  fetch_stage #(
    .PC_WIDTH(32),
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall_d      (stall_d),
    .redirect_d   (redirect_d),
    .redirect_pc_d(redirect_pc_d),
    .instr_d      (instr_d),
    .pc_plus4_d   (pc_plus4_d),
    .valid_d      (valid_d)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall),
    .perf_flush   (perf_flush)
`endif
  );

  typedef struct {
    logic        doReset;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPp4;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pp4;
  } exp_t;

  localparam int NUM_VECS = 33;

  vec_t        vecs[NUM_VECS];
  exp_t        sbQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  logic        wasGrant;
  logic [31:0] wasAddr;
  logic        lastStall, lastRedir;
  int          modelFetched, modelStall, modelFlush;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One clock: the memory model grants with 1-cycle rvalid latency; the scoreboard
  // drops in-flight words on redirect and checks every IF/ID load.
  task automatic tick();
    exp_t e;
    wasGrant  = imem_req && imem_gnt && !rst;
    wasAddr   = imem_addr;
    lastStall = stall_d;
    lastRedir = redirect_d;
    if (redirect_d) sbQ.delete();
    else if (wasGrant) sbQ.push_back('{memWord(wasAddr), wasAddr + 32'd4});
    @(posedge clk);
    #1;
    imem_rvalid = wasGrant;
    imem_rdata  = wasGrant ? memWord(wasAddr) : 32'h0;
    if (!lastStall && !lastRedir && valid_d === 1'b1) begin
      if (sbQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL sb_unexpected_load: got instr %h pc_plus4 %h, expected no load", instr_d, pc_plus4_d);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_instr", instr_d, e.instr);
        checkOutput("sb_pc_plus4", pc_plus4_d, e.pp4);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.doReset) begin
      rst = 1'b1;
      #1;
      rst = 1'b0;
      sbQ.delete();
      modelFetched = 0;
      modelStall   = 0;
      modelFlush   = 0;
    end
    stall_d       = v.stall;
    redirect_d    = v.redir;
    redirect_pc_d = v.rpc;
    imem_gnt      = v.gnt;
    if (!v.stall && !v.redir && v.expValid) modelFetched++;
    if (v.stall) modelStall++;
    if (v.redir) modelFlush++;
    tick();
  endtask

  initial begin
    // {doReset, stall, redir, rpc, gnt, expReq, expAddr, expValid, expPp4}
    vecs[0]  = '{0, 0, 0, 32'h0,         1, 1, 32'h100,       0, 32'h0};
    vecs[1]  = '{0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0};
    vecs[2]  = '{0, 0, 0, 32'h0,         1, 1, 32'h104,       1, 32'h104};
    vecs[3]  = '{0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h104};
    vecs[4]  = '{0, 0, 0, 32'h0,         1, 1, 32'h108,       1, 32'h108};
    vecs[5]  = '{0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h108};
    vecs[6]  = '{0, 0, 0, 32'h0,         1, 1, 32'h10C,       1, 32'h10C};
    vecs[7]  = '{1, 0, 0, 32'h0,         1, 1, 32'h100,       0, 32'h0};
    vecs[8]  = '{0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0};
    vecs[9]  = '{0, 0, 0, 32'h0,         1, 1, 32'h104,       1, 32'h104};
    vecs[10] = '{0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h104};
    vecs[11] = '{0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h104};
    vecs[12] = '{0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h104};
    vecs[13] = '{0, 0, 0, 32'h0,         1, 1, 32'h108,       1, 32'h108};
    vecs[14] = '{0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h108};
    vecs[15] = '{0, 0, 1, 32'h200,       1, 1, 32'h200,       0, 32'h108};
    vecs[16] = '{0, 0, 1, 32'h300,       1, 0, 32'h0,         0, 32'h108};
    vecs[17] = '{0, 0, 0, 32'h0,         1, 1, 32'h300,       0, 32'h108};
    vecs[18] = '{0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h108};
    vecs[19] = '{0, 0, 0, 32'h0,         1, 1, 32'h304,       1, 32'h304};
    vecs[20] = '{0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h304};
    vecs[21] = '{0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h304};
    vecs[22] = '{0, 1, 1, 32'h400,       1, 1, 32'h400,       0, 32'h304};
    vecs[23] = '{0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h304};
    vecs[24] = '{0, 0, 0, 32'h0,         1, 1, 32'h404,       1, 32'h404};
    vecs[25] = '{0, 0, 1, 32'hFFFF_FFFF, 1, 0, 32'h0,         0, 32'h404};
    vecs[26] = '{0, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h404};
    vecs[27] = '{0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h404};
    vecs[28] = '{0, 0, 0, 32'h0,         1, 1, 32'h0,         1, 32'h0};
    vecs[29] = '{0, 0, 0, 32'h0,         0, 1, 32'h0,         0, 32'h0};
    vecs[30] = '{0, 0, 1, 32'h500,       0, 1, 32'h500,       0, 32'h0};
    vecs[31] = '{0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0};
    vecs[32] = '{0, 0, 0, 32'h0,         1, 1, 32'h504,       1, 32'h504};

    rst           = 1'b1;
    imem_gnt      = 1'b1;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    stall_d       = 1'b0;
    redirect_d    = 1'b0;
    redirect_pc_d = 32'h0;
    modelFetched  = 0;
    modelStall    = 0;
    modelFlush    = 0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset imem_req", {31'b0, imem_req}, 32'h0);
    checkOutput("reset valid_d", {31'b0, valid_d}, 32'h0);
    checkOutput("reset instr_d", instr_d, 32'h0);
    checkOutput("reset pc_plus4_d", pc_plus4_d, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].expReq});
      if (vecs[i].expReq) checkOutput($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d valid_d", i), {31'b0, valid_d}, {31'b0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d pc_plus4_d", i), pc_plus4_d, vecs[i].expPp4);
      if (!vecs[i].expValid) checkOutput($sformatf("vec%0d instr_d bubble", i), instr_d, 32'h0);
    end

`ifdef FETCH_PERF_EN
    checkOutput("perf_fetched", perf_fetched, modelFetched);
    checkOutput("perf_stall", perf_stall, modelStall);
    checkOutput("perf_flush", perf_flush, modelFlush);
`endif

    // Reset pulse while a response is in flight: the late rvalid must be ignored.
    stall_d    = 1'b0;
    redirect_d = 1'b0;
    imem_gnt   = 1'b1;
    tick();
    checkOutput("inflight imem_req", {31'b0, imem_req}, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("midreset imem_req", {31'b0, imem_req}, 32'h0);
    checkOutput("midreset valid_d", {31'b0, valid_d}, 32'h0);
    checkOutput("midreset instr_d", instr_d, 32'h0);
    checkOutput("midreset pc_plus4_d", pc_plus4_d, 32'h0);
`ifdef FETCH_PERF_EN
    checkOutput("midreset perf_fetched", perf_fetched, 32'h0);
    checkOutput("midreset perf_stall", perf_stall, 32'h0);
    checkOutput("midreset perf_flush", perf_flush, 32'h0);
`endif
    rst = 1'b0;
    sbQ.delete();
    checkOutput("late rvalid present", {31'b0, imem_rvalid}, 32'h1);
    tick();
    checkOutput("postreset valid_d", {31'b0, valid_d}, 32'h0);
    checkOutput("postreset imem_req", {31'b0, imem_req}, 32'h1);
    checkOutput("postreset imem_addr", imem_addr, 32'h100);
    tick();
    checkOutput("restart wait imem_req", {31'b0, imem_req}, 32'h0);
    tick();
    checkOutput("restart valid_d", {31'b0, valid_d}, 32'h1);
    checkOutput("restart pc_plus4_d", pc_plus4_d, 32'h104);
    checkOutput("restart imem_addr", imem_addr, 32'h104);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
